// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, parity
// type encodings and the default payload width.
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_par_calc.sv
// Combinational parity generator: even parity is the XOR-reduction of the
// payload, odd parity is its inverse.
module uart_par_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_type,
    output logic                  par_bit
);

    assign par_bit = (^data) ^ (par_type == PAR_ODD);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: latches a payload on request and serialises it
// as start / LSB-first data / optional parity / stop, one bit per TX_tick.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  TX_tick,
    input  logic                  DATA_VALID,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_e               state;
    tx_state_e               state_next;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [DATA_WIDTH-1:0]   shift_rot;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    par_en_lat;
    logic                    par_typ_lat;
    logic                    par_bit;
    logic                    last_bit;
    logic                    tx_next;
    logic                    busy_next;

    // The shift register rotates rather than shifts: after DATA_WIDTH rotations
    // it holds the original payload again, exactly when the parity bit is needed.
    assign shift_rot = (shift_reg >> 1) | (shift_reg << (DATA_WIDTH - 1));
    assign last_bit  = (bit_cnt == LAST_BIT);

    uart_par_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_par_calc (
        .data     (shift_reg),
        .par_type (par_typ_lat),
        .par_bit  (par_bit)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (DATA_VALID)            state_next = ARMED;
            ARMED:   if (TX_tick)               state_next = START;
            START:   if (TX_tick)               state_next = DATA;
            DATA:    if (TX_tick && last_bit)   state_next = par_en_lat ? PARITY : STOP;
            PARITY:  if (TX_tick)               state_next = STOP;
            STOP:    if (TX_tick)               state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_next   = TX_OUT;
        busy_next = busy;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (DATA_VALID) busy_next = 1'b1;
            end
            ARMED:  if (TX_tick) tx_next = 1'b0;
            START:  if (TX_tick) tx_next = shift_reg[0];
            DATA: begin
                if (TX_tick) begin
                    if (!last_bit)       tx_next = shift_reg[0];
                    else if (par_en_lat) tx_next = par_bit;
                    else                 tx_next = 1'b1;
                end
            end
            PARITY: if (TX_tick) tx_next = 1'b1;
            STOP: begin
                tx_next = 1'b1;
                if (TX_tick) busy_next = 1'b0;
            end
            default: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
            end
        endcase
    end

    // Registered outputs plus the payload, counter and parity-control latches.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            TX_OUT      <= 1'b1;
            busy        <= 1'b0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            par_en_lat  <= 1'b0;
            par_typ_lat <= 1'b0;
        end else begin
            TX_OUT <= tx_next;
            busy   <= busy_next;
            case (state)
                IDLE: begin
                    if (DATA_VALID) begin
                        shift_reg   <= P_DATA;
                        par_en_lat  <= PAR_EN;
                        par_typ_lat <= PAR_TYP;
                    end
                end
                START: begin
                    if (TX_tick) begin
                        shift_reg <= shift_rot;
                        bit_cnt   <= '0;
                    end
                end
                DATA: begin
                    if (TX_tick && !last_bit) begin
                        shift_reg <= shift_rot;
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed corner cases plus random
// frames compared against a bit-list model of the serial line.
module tb_uart_tx_ctrl;

    localparam int W = 8;

    logic         CLK        = 1'b0;
    logic         RST        = 1'b1;
    logic         TX_tick    = 1'b0;
    logic         DATA_VALID = 1'b0;
    logic [W-1:0] P_DATA     = '0;
    logic         PAR_EN     = 1'b0;
    logic         PAR_TYP    = 1'b0;
    logic         TX_OUT;
    logic         busy;

    int   checks = 0;
    int   errors = 0;
    logic expBits[$];

    uart_tx_ctrl #(
        .DATA_WIDTH (W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .TX_tick    (TX_tick),
        .DATA_VALID (DATA_VALID),
        .P_DATA     (P_DATA),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    // Expected line value after each tick: start, data LSB first, parity, stop.
    function automatic void buildFrame(input logic [W-1:0] d, input logic pe, input logic pt);
        expBits.delete();
        expBits.push_back(1'b0);
        for (int i = 0; i < W; i++) expBits.push_back(d[i]);
        if (pe) expBits.push_back((($countones(d) % 2) == 1) ^ pt);
        expBits.push_back(1'b1);
    endfunction

    task automatic applyStimulus(input logic [W-1:0] d, input logic pe, input logic pt,
                                 input bit coincident);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        DATA_VALID = 1'b1;
        TX_tick    = coincident;
        cycle();
        DATA_VALID = 1'b0;
        TX_tick    = 1'b0;
        checkOutput("accept_busy", busy, 1'b1);
        checkOutput("armed_line", TX_OUT, 1'b1);
        P_DATA  = W'($urandom);
        PAR_EN  = 1'($urandom);
        PAR_TYP = 1'($urandom);
    endtask

    task automatic runFrame(input logic [W-1:0] d, input logic pe, input logic pt,
                            input bit inject, input bit holdAfter,
                            input logic [W-1:0] nd, input logic npe, input logic npt);
        logic prev;
        int   gap;
        buildFrame(d, pe, pt);
        prev = 1'b1;
        foreach (expBits[i]) begin
            gap = inject ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                if (inject && g == 0) begin
                    DATA_VALID = 1'b1;
                    P_DATA     = {W{1'b1}};
                end
                cycle();
                DATA_VALID = 1'b0;
                checkOutput("hold_line", TX_OUT, prev);
                checkOutput("hold_busy", busy, 1'b1);
            end
            TX_tick = 1'b1;
            cycle();
            TX_tick = 1'b0;
            checkOutput($sformatf("line_tick%0d", i), TX_OUT, expBits[i]);
            checkOutput("frame_busy", busy, 1'b1);
            prev = expBits[i];
        end
        if (holdAfter) begin
            DATA_VALID = 1'b1;
            P_DATA     = nd;
            PAR_EN     = npe;
            PAR_TYP    = npt;
        end
        TX_tick = 1'b1;
        cycle();
        TX_tick = 1'b0;
        checkOutput("busy_fall", busy, 1'b0);
        checkOutput("stop_line", TX_OUT, 1'b1);
    endtask

    task automatic idleCheck(input int n);
        for (int k = 0; k < n; k++) begin
            TX_tick = 1'($urandom);
            cycle();
            TX_tick = 1'b0;
            checkOutput("idle_busy", busy, 1'b0);
            checkOutput("idle_line", TX_OUT, 1'b1);
        end
    endtask

    task automatic resetMidFrame();
        applyStimulus(8'hC3, 1'b0, 1'b0, 1'b0);
        buildFrame(8'hC3, 1'b0, 1'b0);
        for (int i = 0; i <= 4; i++) begin
            TX_tick = 1'b1;
            cycle();
            TX_tick = 1'b0;
            checkOutput($sformatf("pre_reset_tick%0d", i), TX_OUT, expBits[i]);
        end
        #2;
        RST = 1'b0;
        #1;
        checkOutput("async_reset_line", TX_OUT, 1'b1);
        checkOutput("async_reset_busy", busy, 1'b0);
        TX_tick = 1'b1;
        cycle();
        TX_tick = 1'b0;
        #4;
        RST = 1'b1;
        for (int k = 0; k < 4; k++) begin
            TX_tick = 1'b1;
            cycle();
            TX_tick = 1'b0;
            checkOutput("no_resume_line", TX_OUT, 1'b1);
            checkOutput("no_resume_busy", busy, 1'b0);
        end
    endtask

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] d2;
        logic         pe;
        logic         pt;
        bit           inj;

        #2;
        RST = 1'b0;
        repeat (3) cycle();
        checkOutput("reset_line", TX_OUT, 1'b1);
        checkOutput("reset_busy", busy, 1'b0);
        #4;
        RST = 1'b1;
        idleCheck(2);

        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0);
        runFrame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        idleCheck(2);

        applyStimulus(8'hA5, 1'b1, 1'b1, 1'b0);
        runFrame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        idleCheck(2);

        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
        runFrame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        idleCheck(2);

        applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0);
        runFrame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        idleCheck(3);

        applyStimulus(8'h96, 1'b1, 1'b1, 1'b1);
        runFrame(8'h96, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        idleCheck(2);

        // Back-to-back: request held through the busy-fall edge, accepted one edge later.
        d  = W'($urandom);
        d2 = W'($urandom);
        applyStimulus(d, 1'b0, 1'b0, 1'b0);
        runFrame(d, 1'b0, 1'b0, 1'b0, 1'b1, d2, 1'b1, 1'b1);
        cycle();
        DATA_VALID = 1'b0;
        checkOutput("b2b_accept_busy", busy, 1'b1);
        checkOutput("b2b_armed_line", TX_OUT, 1'b1);
        runFrame(d2, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        idleCheck(2);

        resetMidFrame();
        d = W'($urandom);
        applyStimulus(d, 1'b1, 1'b0, 1'b0);
        runFrame(d, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        idleCheck(2);

        for (int n = 0; n < 24; n++) begin
            d   = W'($urandom);
            pe  = 1'($urandom);
            pt  = 1'($urandom);
            inj = 1'($urandom);
            applyStimulus(d, pe, pt, 1'($urandom));
            runFrame(d, pe, pt, inj, 1'b0, '0, 1'b0, 1'b0);
            idleCheck(int'($urandom_range(1, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the payload bits per frame.
REQ-002 The block SHALL have port CLK  input  1  system clock, with all state updated on the rising edge.
REQ-003 The block SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port TX_tick  input  1  baud strobe, one CLK wide, that marks each bit boundary.
REQ-005 The block SHALL have port DATA_VALID  input  1  request to send P_DATA.
REQ-006 The block SHALL have port P_DATA  input  DATA_WIDTH  parallel payload.
REQ-007 The block SHALL have port PAR_EN  input  1  which inserts a parity bit when 1.
REQ-008 The block SHALL have port PAR_TYP  input  1  parity type, 0 = even, 1 = odd.
REQ-009 The block SHALL have port TX_OUT  output  1  registered serial line, idle high.
REQ-010 The block SHALL have port busy  output  1  registered, high from acceptance until the frame ends.

Function
REQ-011 The FSM SHALL have exactly these states: IDLE, ARMED, START, DATA, PARITY, STOP.
REQ-012 Acceptance SHALL occur in IDLE on any CLK edge with DATA_VALID=1, independent of TX_tick.
- On acceptance, P_DATA, PAR_EN and PAR_TYP are latched.
- busy = 1 on the next cycle.
- The state moves to ARMED.
REQ-013 DATA_VALID SHALL be ignored in every state except IDLE, and latched values SHALL NOT change while busy=1.
REQ-014 All transitions out of ARMED, START, DATA, PARITY and STOP SHALL occur only on edges where TX_tick=1, with no change otherwise.
REQ-015 On a tick in ARMED, the state SHALL move to START and TX_OUT SHALL become 0.
REQ-016 On a tick in START, the state SHALL move to DATA, TX_OUT SHALL become data bit 0, and the bit counter SHALL be cleared.
REQ-017 On a tick in DATA with counter < DATA_WIDTH-1, TX_OUT SHALL become the next bit (LSB first) and the counter SHALL increment.
REQ-018 On a tick in DATA with counter = DATA_WIDTH-1, the block SHALL move to PARITY with TX_OUT = parity bit if PAR_EN is latched 1, otherwise to STOP with TX_OUT = 1.
REQ-019 Parity SHALL be the XOR-reduction of the latched data for even, and its inverse for odd.
REQ-020 On a tick in PARITY, the state SHALL move to STOP and TX_OUT SHALL become 1.
REQ-021 On a tick in STOP, the state SHALL move to IDLE, busy SHALL become 0, and TX_OUT SHALL remain 1.
REQ-022 A frame SHALL last exactly DATA_WIDTH+2 tick periods, plus 1 when parity is enabled.
- The frame is measured from the TX_OUT falling edge to the busy fall.
REQ-023 DATA_VALID=1 on the same edge that busy falls SHALL be ignored.
- DATA_VALID held high on the following edge SHALL be accepted there.
REQ-024 DATA_VALID and TX_tick coincident in IDLE SHALL latch the data and enter ARMED only.
- The START bit SHALL begin on the next tick, not that one.
REQ-025 The bit counter SHALL be $clog2(DATA_WIDTH) bits wide and SHALL never wrap past DATA_WIDTH-1.
REQ-026 TX_OUT SHALL be 1 in IDLE, ARMED and STOP.

Reset
REQ-027 RST=0 SHALL asynchronously force the following regardless of CLK:
- state IDLE, TX_OUT = 1, busy = 0;
- counter, data and parity latches = 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame, with the line high immediately and no partial resumption after release.
REQ-029 After RST release, the first acceptance SHALL require a fresh DATA_VALID sampled on a CLK edge.

Structure
REQ-030 Shared package uart_pkg SHALL hold:
- the FSM state enum;
- parity-type constants PAR_EVEN = 0 and PAR_ODD = 1;
- the default DATA_WIDTH.
REQ-031 Parity computation SHALL live in one combinational sub-module, uart_par_calc, with inputs data and type and output bit.
REQ-032 The shift register, counter and FSM SHALL reside in uart_tx_ctrl.

Verification
REQ-033 P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> line per tick SHALL be 0,1,0,1,0,0,1,0,1,0,1 (parity 0), followed by busy low after 11 ticks.
REQ-034 P_DATA=0xA5, PAR_EN=1, PAR_TYP=1 -> parity bit SHALL be 1, and a frame of 11 ticks SHALL result.
REQ-035 P_DATA=0x00, PAR_EN=0 -> line SHALL be 0, eight 0s, then 1, and busy SHALL fall after exactly 10 ticks.
REQ-036 DATA_VALID pulsed with 0xFF during a frame of 0x3C -> 0x3C SHALL be sent intact, 0xFF SHALL NOT be sent, and P_DATA changes mid-frame SHALL have no effect.
REQ-037 RST pulsed low during the 4th data bit -> TX_OUT=1 and busy=0 SHALL hold within the same cycle, and the next request SHALL produce a full clean frame.
REQ-038 DATA_VALID coincident with TX_tick in IDLE -> START SHALL appear on the following tick, and DATA_VALID held high SHALL cause back-to-back frames with exactly one ARMED period between them.
